mpu_initiator: RTL and testbench

- Initiator side of the MPU command interface (cs/cfg/core_id/addr/wdata/free_reserve/we to rdy/bsy/rdata/err).
- Accepts one request at a time from a valid/ready upstream channel and encodes its op onto MPU control signals.
- Issues a single-cycle cs strobe, waits for rdy, and returns rdata/err plus the originating core_id on a valid/ready response channel.
- Sits between the core-side request mux and the mpu instance.

---
 rtl/mpu_initiator.sv | 194 +++++++++++++++++++
 tb/tb_mpu_initiator.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_initiator.sv
// mpu_initiator: initiator side of the MPU command interface.
// Takes one request at a time from a valid/ready channel, encodes its op onto
// the MPU control signals, fires a single-cycle cs strobe once the MPU is not
// busy, waits for rdy, and returns rdata/err with the requesting core_id on a
// valid/ready response channel.
// Optional build macro: MPU_INIT_TIMEOUT_EN adds a rdy wait limit of
// TIMEOUT_CYCLES; on expiry the response carries err = all ones, rdata = 0.
module mpu_initiator #(
  parameter int unsigned CORE_ID_WIDTH  = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ERR_WIDTH      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  // request channel
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [CORE_ID_WIDTH-1:0] req_core_id,
  input  logic [1:0]               req_op,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  // response channel
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [CORE_ID_WIDTH-1:0] rsp_core_id,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic [ERR_WIDTH-1:0]     rsp_err,
  // MPU command interface
  output logic                     mpu_cs,
  output logic                     mpu_cfg,
  output logic [CORE_ID_WIDTH-1:0] mpu_core_id,
  output logic [ADDR_WIDTH-1:0]    mpu_addr,
  output logic [DATA_WIDTH-1:0]    mpu_wdata,
  output logic                     mpu_free_reserve,
  output logic                     mpu_we,
  input  logic                     mpu_rdy,
  input  logic                     mpu_bsy,
  input  logic [DATA_WIDTH-1:0]    mpu_rdata,
  input  logic [ERR_WIDTH-1:0]     mpu_err
);

  // A zero wait limit would make the timeout fire before the MPU can answer.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("mpu_initiator: TIMEOUT_CYCLES must be nonzero");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                   state_q;
  logic                     req_ready_q;
  logic                     rsp_valid_q;
  logic [CORE_ID_WIDTH-1:0] rsp_core_id_q;
  logic [DATA_WIDTH-1:0]    rsp_rdata_q;
  logic [ERR_WIDTH-1:0]     rsp_err_q;
  logic                     mpu_cs_q;
  logic                     mpu_cfg_q;
  logic [CORE_ID_WIDTH-1:0] mpu_core_id_q;
  logic [ADDR_WIDTH-1:0]    mpu_addr_q;
  logic [DATA_WIDTH-1:0]    mpu_wdata_q;
  logic                     mpu_free_reserve_q;
  logic                     mpu_we_q;

  // Next values of the MPU control bits decoded from the incoming op.
  logic cfg_d;
  logic free_reserve_d;
  logic we_d;

`ifdef MPU_INIT_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt_q;
`endif

  // Op decode: 00 check-read, 01 check-write, 10 reserve, 11 release.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    cfg_d          = 1'b0;
    free_reserve_d = 1'b0;
    we_d           = 1'b0;
    case (req_op)
      2'b01:   we_d = 1'b1;
      2'b10: begin
        cfg_d          = 1'b1;
        free_reserve_d = 1'b1;
      end
      2'b11:   cfg_d = 1'b1;
      default: ;
    endcase
  end

  // Request/issue/wait/respond sequencer; all outputs are registered here.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      state_q            <= ST_IDLE;
      req_ready_q        <= 1'b0;
      rsp_valid_q        <= 1'b0;
      rsp_core_id_q      <= '0;
      rsp_rdata_q        <= '0;
      rsp_err_q          <= '0;
      mpu_cs_q           <= 1'b0;
      mpu_cfg_q          <= 1'b0;
      mpu_core_id_q      <= '0;
      mpu_addr_q         <= '0;
      mpu_wdata_q        <= '0;
      mpu_free_reserve_q <= 1'b0;
      mpu_we_q           <= 1'b0;
`ifdef MPU_INIT_TIMEOUT_EN
      tmo_cnt_q          <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            mpu_core_id_q      <= req_core_id;
            mpu_addr_q         <= req_addr;
            mpu_wdata_q        <= req_wdata;
            mpu_cfg_q          <= cfg_d;
            mpu_free_reserve_q <= free_reserve_d;
            mpu_we_q           <= we_d;
            req_ready_q        <= 1'b0;
            // Strobe straight away if the MPU is already idle.
            mpu_cs_q           <= ~mpu_bsy;
            state_q            <= ST_ISSUE;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_ISSUE: begin
          // The cs cycle itself still belongs to ISSUE, so rdy is never
          // sampled while cs is high.
          if (mpu_cs_q) begin
            mpu_cs_q <= 1'b0;
            state_q  <= ST_WAIT;
`ifdef MPU_INIT_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end else if (!mpu_bsy) begin
            mpu_cs_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (mpu_rdy) begin
            rsp_core_id_q <= mpu_core_id_q;
            rsp_rdata_q   <= mpu_rdata;
            rsp_err_q     <= mpu_err;
            rsp_valid_q   <= 1'b1;
            state_q       <= ST_RESP;
          end
`ifdef MPU_INIT_TIMEOUT_EN
          else if (tmo_cnt_q == CNT_LAST) begin
            rsp_core_id_q <= mpu_core_id_q;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= '1;
            rsp_valid_q   <= 1'b1;
            state_q       <= ST_RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready        = req_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_core_id      = rsp_core_id_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_err          = rsp_err_q;
  assign mpu_cs           = mpu_cs_q;
  assign mpu_cfg          = mpu_cfg_q;
  assign mpu_core_id      = mpu_core_id_q;
  assign mpu_addr         = mpu_addr_q;
  assign mpu_wdata        = mpu_wdata_q;
  assign mpu_free_reserve = mpu_free_reserve_q;
  assign mpu_we           = mpu_we_q;

endmodule

// File: tb/tb_mpu_initiator.sv
// Self-checking bench for mpu_initiator: directed transactions plus a
// transaction-level model (expected command / response queues) checked by a
// monitor on every falling edge.
module tb_mpu_initiator;

  localparam int CW  = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int EW  = 3;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_core_id;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [CW-1:0] rsp_core_id;
  logic [DW-1:0] rsp_rdata;
  logic [EW-1:0] rsp_err;
  logic          mpu_cs;
  logic          mpu_cfg;
  logic [CW-1:0] mpu_core_id;
  logic [AW-1:0] mpu_addr;
  logic [DW-1:0] mpu_wdata;
  logic          mpu_free_reserve;
  logic          mpu_we;
  logic          mpu_rdy;
  logic          mpu_bsy;
  logic [DW-1:0] mpu_rdata;
  logic [EW-1:0] mpu_err;

  always #5 clk = ~clk;

  mpu_initiator #(
    .CORE_ID_WIDTH (CW),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .ERR_WIDTH     (EW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_core_id     (req_core_id),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_core_id     (rsp_core_id),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .mpu_cs          (mpu_cs),
    .mpu_cfg         (mpu_cfg),
    .mpu_core_id     (mpu_core_id),
    .mpu_addr        (mpu_addr),
    .mpu_wdata       (mpu_wdata),
    .mpu_free_reserve(mpu_free_reserve),
    .mpu_we          (mpu_we),
    .mpu_rdy         (mpu_rdy),
    .mpu_bsy         (mpu_bsy),
    .mpu_rdata       (mpu_rdata),
    .mpu_err         (mpu_err)
  );

  typedef struct {
    logic [CW-1:0] core;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    logic [CW-1:0] core;
    logic [DW-1:0] rdata;
    logic [EW-1:0] err;
  } rsp_t;

  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];
  int   tests  = 0;
  int   fails  = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Control bits an op must produce: {cfg, free_reserve, we}.
  function automatic logic [2:0] op_ctl(input logic [1:0] op);
    case (op)
      2'b00:   return 3'b000;
      2'b01:   return 3'b001;
      2'b10:   return 3'b110;
      default: return 3'b100;
    endcase
  endfunction

  // Monitor: every cs consumes one expected command, every rising rsp_valid
  // consumes one expected response; protocol invariants checked each cycle.
  initial begin
    bit   prev_cs;
    bit   prev_rv;
    bit   in_flight;
    cmd_t cur;
    rsp_t hold;
    rsp_t er;
    logic [2:0] ctl;
    prev_cs   = 1'b0;
    prev_rv   = 1'b0;
    in_flight = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_cs   = 1'b0;
        prev_rv   = 1'b0;
        in_flight = 1'b0;
      end else begin
        if (mpu_cs) begin
          check("cs_while_rsp_valid", rsp_valid, 0);
          check("cs_single_cycle", prev_cs, 0);
          if (exp_cmd.size() == 0) begin
            check("cs_unexpected", 1, 0);
          end else begin
            cur = exp_cmd.pop_front();
            ctl = op_ctl(cur.op);
            check("cs_core_id", mpu_core_id, cur.core);
            check("cs_addr", mpu_addr, cur.addr);
            check("cs_wdata", mpu_wdata, cur.wdata);
            check("cs_cfg", mpu_cfg, ctl[2]);
            check("cs_we", mpu_we, ctl[0]);
            if (ctl[2]) check("cs_free_reserve", mpu_free_reserve, ctl[1]);
            in_flight = 1'b1;
          end
        end else if (in_flight) begin
          ctl = op_ctl(cur.op);
          check("mpu_fields_stable", {mpu_core_id, mpu_addr, mpu_wdata, mpu_cfg, mpu_we},
                {cur.core, cur.addr, cur.wdata, ctl[2], ctl[0]});
        end
        if (rsp_valid && !prev_rv) begin
          in_flight = 1'b0;
          hold = '{rsp_core_id, rsp_rdata, rsp_err};
          if (exp_rsp.size() == 0) begin
            check("rsp_unexpected", 1, 0);
          end else begin
            er = exp_rsp.pop_front();
            check("model_rsp_core_id", rsp_core_id, er.core);
            check("model_rsp_rdata", rsp_rdata, er.rdata);
            check("model_rsp_err", rsp_err, er.err);
          end
        end else if (rsp_valid && prev_rv) begin
          check("rsp_stable", {rsp_core_id, rsp_rdata, rsp_err}, {hold.core, hold.rdata, hold.err});
        end
        if (rsp_valid) check("req_ready_during_rsp", req_ready, 0);
        prev_cs = mpu_cs;
        prev_rv = rsp_valid;
      end
    end
  end

  // Present a request with the MPU busy for b cycles from acceptance; cs must
  // appear exactly b+1 cycles after acceptance. stray drives rdy (with junk
  // data) from presentation through the cs cycle, which must be ignored.
  task automatic send_req(input logic [CW-1:0] core, input logic [1:0] op,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int b, input bit stray);
    cmd_t c;
    int   waited;
    c = '{core, op, addr, wdata};
    req_valid   = 1'b1;
    req_core_id = core;
    req_op      = op;
    req_addr    = addr;
    req_wdata   = wdata;
    mpu_bsy     = (b > 0);
    mpu_rdy     = stray;
    mpu_rdata   = 32'hBAD0_BAD0;
    mpu_err     = 3'b110;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    exp_cmd.push_back(c);
    for (int k = 1; k <= b + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid   = 1'b0;
        req_addr    = '1;
        req_wdata   = '1;
        req_core_id = ~core;
      end
      check("cs_timing", mpu_cs, (k == b + 1));
      mpu_bsy = (k < b);
    end
  endtask

  // Hold rsp_ready low for stall cycles (with a competing request pending),
  // then complete the handshake.
  task automatic consume(input int stall);
    for (int s = 0; s < stall; s++) begin
      rsp_ready   = 1'b0;
      req_valid   = 1'b1;
      req_core_id = 2'd3;
      req_op      = 2'b01;
      req_addr    = 32'hFFFF_0000;
      @(negedge clk);
      check("rsp_hold_valid", rsp_valid, 1);
      check("req_ready_stall", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_clear", rsp_valid, 0);
    check("req_ready_after_hs", req_ready, 1);
  endtask

  // Answer with rdy d cycles after the cs cycle; the response must appear in
  // the following cycle and not before.
  task automatic finish_rsp(input logic [CW-1:0] core, input logic [DW-1:0] rdata,
                            input logic [EW-1:0] err, input int d, input int stall);
    rsp_t r;
    r = '{core, rdata, err};
    for (int j = 1; j <= d; j++) begin
      @(negedge clk);
      check("rsp_early", rsp_valid, 0);
      if (j == d) begin
        exp_rsp.push_back(r);
        mpu_rdy   = 1'b1;
        mpu_rdata = rdata;
        mpu_err   = err;
      end else begin
        mpu_rdy   = 1'b0;
        mpu_rdata = 32'h1357_9BDF;
      end
    end
    @(negedge clk);
    mpu_rdy   = 1'b0;
    mpu_rdata = 32'h5A5A_5A5A;
    mpu_err   = 3'b101;
    check("rsp_valid_rise", rsp_valid, 1);
    check("rsp_core_id", rsp_core_id, core);
    check("rsp_rdata", rsp_rdata, rdata);
    check("rsp_err", rsp_err, err);
    consume(stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_core_id = '0;
    req_op      = '0;
    req_addr    = '0;
    req_wdata   = '0;
    rsp_ready   = 1'b0;
    mpu_rdy     = 1'b0;
    mpu_bsy     = 1'b1;
    mpu_rdata   = '0;
    mpu_err     = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {req_ready, rsp_valid, rsp_core_id, rsp_rdata, rsp_err, mpu_cs, mpu_cfg,
           mpu_core_id, mpu_addr, mpu_wdata, mpu_free_reserve, mpu_we}, 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Reserve from core 2 while the MPU is still busy for 5 cycles.
    send_req(2'd2, 2'b10, 32'h4, 32'h0000_00FC, 5, 1'b0);
    check("t1_cfg", mpu_cfg, 1);
    check("t1_free_reserve", mpu_free_reserve, 1);
    check("t1_we", mpu_we, 0);
    finish_rsp(2'd2, 32'h40, 3'd0, 1, 0);

    // Check-write from core 1 with error 3, stray rdy during cs, 4-cycle stall.
    send_req(2'd1, 2'b01, 32'h44, 32'h0, 0, 1'b1);
    check("t2_cfg", mpu_cfg, 0);
    check("t2_we", mpu_we, 1);
    finish_rsp(2'd1, 32'h0, 3'd3, 2, 4);

    // Back-to-back reserve then release.
    send_req(2'd0, 2'b10, 32'h8, 32'h0000_00F0, 0, 1'b0);
    finish_rsp(2'd0, 32'h80, 3'd0, 1, 0);
    send_req(2'd0, 2'b11, 32'h40, 32'h0, 2, 1'b0);
    check("t4_cfg", mpu_cfg, 1);
    check("t4_free_reserve", mpu_free_reserve, 0);
    finish_rsp(2'd0, 32'h0, 3'd0, 3, 1);

    // Check-read from core 3.
    send_req(2'd3, 2'b00, 32'h1234, 32'h0, 1, 1'b1);
    check("t5_cfg", mpu_cfg, 0);
    check("t5_we", mpu_we, 0);
    finish_rsp(2'd3, 32'hCAFE, 3'd5, 1, 2);

    // Reset in WAIT: request dropped, stray rdy ignored afterwards.
    send_req(2'd1, 2'b00, 32'h10, 32'h0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_pre_rsp_valid", rsp_valid, 0);
    mon_en  = 1'b0;
    rst     = 1'b1;
    mpu_rdy = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs",
          {req_ready, rsp_valid, rsp_core_id, rsp_rdata, rsp_err, mpu_cs, mpu_cfg,
           mpu_core_id, mpu_addr, mpu_wdata, mpu_free_reserve, mpu_we}, 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_rsp", rsp_valid, 0);
      check("rst_no_cs", mpu_cs, 0);
    end
    mpu_rdy = 1'b0;
    mon_en  = 1'b1;
    // Next request must again wait for bsy to drop.
    send_req(2'd2, 2'b11, 32'h40, 32'h0, 3, 1'b0);
    finish_rsp(2'd2, 32'h0, 3'd0, 1, 0);

    // Unanswered request.
    send_req(2'd1, 2'b00, 32'h20, 32'h0, 0, 1'b0);
`ifdef MPU_INIT_TIMEOUT_EN
    exp_rsp.push_back('{2'd1, 32'h0, 3'b111});
    for (int j = 1; j <= TMO; j++) begin
      @(negedge clk);
      check("tmo_early", rsp_valid, 0);
    end
    @(negedge clk);
    check("tmo_rsp_valid", rsp_valid, 1);
    check("tmo_rsp_err", rsp_err, 3'b111);
    check("tmo_rsp_rdata", rsp_rdata, 0);
    check("tmo_rsp_core_id", rsp_core_id, 2'd1);
    mpu_rdy = 1'b1;
    consume(2);
    repeat (2) begin
      @(negedge clk);
      check("tmo_late_rdy", rsp_valid, 0);
    end
    mpu_rdy = 1'b0;
`else
    finish_rsp(2'd1, 32'h77, 3'd2, 20, 0);
`endif

    repeat (2) @(negedge clk);
    check("cmd_queue_empty", exp_cmd.size(), 0);
    check("rsp_queue_empty", exp_rsp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
